// File: rtl/ctrl_block_packer_if.sv
// ctrl_block_packer_if: command, word-stream and memory write-port signals of
// the control block packer. The master side is the upstream producer (plus the
// memory observing the write port); the slave side is the packer itself.
// The optional multi-block command input exists only when
// CTRL_PACKER_MULTIBLOCK_EN is defined.
interface ctrl_block_packer_if #(
    parameter int ADDR_BITS   = 6,
    parameter int BLOCK_WIDTH = 8,
    parameter int WORD_BITS   = 16
);
    localparam int LINE_BITS = WORD_BITS * BLOCK_WIDTH * BLOCK_WIDTH;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_BITS-1:0] cmd_addr;
`ifdef CTRL_PACKER_MULTIBLOCK_EN
    logic [ADDR_BITS-1:0] cmd_nblocks;
`endif
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_BITS-1:0] in_word;
    logic                 mem_write;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [LINE_BITS-1:0] mem_data;
    logic                 busy;
    logic                 done;

`ifdef CTRL_PACKER_MULTIBLOCK_EN
    modport master (
        output cmd_valid, cmd_addr, cmd_nblocks, in_valid, in_word,
        input  cmd_ready, in_ready, mem_write, mem_addr, mem_data, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_addr, cmd_nblocks, in_valid, in_word,
        output cmd_ready, in_ready, mem_write, mem_addr, mem_data, busy, done
    );
`else
    modport master (
        output cmd_valid, cmd_addr, in_valid, in_word,
        input  cmd_ready, in_ready, mem_write, mem_addr, mem_data, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_addr, in_valid, in_word,
        output cmd_ready, in_ready, mem_write, mem_addr, mem_data, busy, done
    );
`endif
endinterface

// File: rtl/ctrl_block_packer.sv
// ctrl_block_packer: collects BLOCK_WIDTH**2 stream words (row-major) into one
// block line and issues a single-cycle write of that line to the control
// memory at the commanded block address.
// Optional feature macro: CTRL_PACKER_MULTIBLOCK_EN -- a command carries a
// block count and consecutive blocks are written to incrementing addresses.
// Every output is a register; nothing combinational reaches an output port.
module ctrl_block_packer #(
    parameter int ADDR_BITS   = 6,
    parameter int BLOCK_WIDTH = 8,
    parameter int WORD_BITS   = 16
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_block_packer_if.slave io_bus
);
    localparam int NWORDS    = BLOCK_WIDTH * BLOCK_WIDTH;
    localparam int CNT_W     = $clog2(NWORDS) + 1;
    localparam int LINE_BITS = WORD_BITS * NWORDS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_cmd_ready;
    logic                 r_in_ready;
    logic                 r_mem_write;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic [LINE_BITS-1:0] r_mem_data;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_cmd_fire;
    logic                 w_in_fire;
    logic [CNT_W-2:0]     w_slot;
    logic                 w_final;

    // Handshakes use the registered ready flags, so acceptance always agrees
    // with what the producer saw on the ready outputs.
    assign w_cmd_fire = io_bus.cmd_valid && r_cmd_ready;
    assign w_in_fire  = io_bus.in_valid && r_in_ready;
    assign w_slot     = r_cnt[CNT_W-2:0];

`ifdef CTRL_PACKER_MULTIBLOCK_EN
    logic [ADDR_BITS-1:0] r_blocks_left;
    logic [ADDR_BITS-1:0] w_nblocks;

    // A block count of zero is treated as a single block.
    assign w_nblocks = (io_bus.cmd_nblocks == '0) ? ADDR_BITS'(1) : io_bus.cmd_nblocks;
    assign w_final   = (r_blocks_left == ADDR_BITS'(1));
`else
    assign w_final   = 1'b1;
`endif

    // Packer FSM: command latch, word fill, one-cycle commit with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef CTRL_PACKER_MULTIBLOCK_EN
            r_blocks_left <= '0;
`endif
        end else begin
            // Strobes default low so they can only ever last one cycle.
            r_mem_write <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        r_state     <= FILL;
                        r_mem_addr  <= io_bus.cmd_addr;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
`ifdef CTRL_PACKER_MULTIBLOCK_EN
                        r_blocks_left <= w_nblocks;
`endif
                    end
                end
                FILL: begin
                    if (w_in_fire) begin
                        r_mem_data[w_slot*WORD_BITS +: WORD_BITS] <= io_bus.in_word;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_IDX) begin
                            // Write strobe rises together with the COMMIT state.
                            r_state     <= COMMIT;
                            r_in_ready  <= 1'b0;
                            r_mem_write <= 1'b1;
                            r_done      <= w_final;
                        end
                    end
                end
                COMMIT: begin
`ifdef CTRL_PACKER_MULTIBLOCK_EN
                    if (!w_final) begin
                        // Next block of the same command goes to the following address.
                        r_state       <= FILL;
                        r_mem_addr    <= r_mem_addr + ADDR_BITS'(1);
                        r_cnt         <= '0;
                        r_in_ready    <= 1'b1;
                        r_blocks_left <= r_blocks_left - ADDR_BITS'(1);
                    end else begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
`else
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
`endif
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.cmd_ready = r_cmd_ready;
    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.mem_write = r_mem_write;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_data  = r_mem_data;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;

endmodule

// File: tb/tb_ctrl_block_packer.sv
// tb_ctrl_block_packer: directed stimulus for ctrl_block_packer with a
// transaction-level model of the packer (word slots, addresses, block counts)
// checked against every DUT output on each falling clock edge, plus literal
// expectations for the directed scenarios.
module tb_ctrl_block_packer;
    localparam int AB = 6;
    localparam int BW = 8;
    localparam int WB = 16;
    localparam int NW = BW * BW;
    localparam int LB = WB * NW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_block_packer_if #(.ADDR_BITS(AB), .BLOCK_WIDTH(BW), .WORD_BITS(WB)) ifc ();

    ctrl_block_packer #(.ADDR_BITS(AB), .BLOCK_WIDTH(BW), .WORD_BITS(WB)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (ifc)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: slot contents, target address, blocks still to write.
    logic [WB-1:0] m_slot [NW];
    bit            m_active = 1'b0;
    bit            m_commit = 1'b0;
    bit            m_rdy    = 1'b0;
    bit            started  = 1'b0;
    logic [AB-1:0] m_addr   = '0;
    logic [AB-1:0] m_left   = '0;
    int            m_k      = 0;

    logic [AB-1:0] wr_log[$];
    int            done_cnt = 0;

    function automatic logic [LB-1:0] m_line();
        logic [LB-1:0] l;
        for (int k = 0; k < NW; k++) l[k*WB +: WB] = m_slot[k];
        return l;
    endfunction

    function automatic logic [WB-1:0] slot(input int k);
        return ifc.mem_data[k*WB +: WB];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string nm, input logic [LB-1:0] exp);
        int bad_k;
        n_vec++;
        if (ifc.mem_data !== exp) begin
            n_bad++;
            bad_k = 0;
            for (int k = NW - 1; k >= 0; k--)
                if (ifc.mem_data[k*WB +: WB] !== exp[k*WB +: WB]) bad_k = k;
            $display("FAIL %s: slot %0d got %0h, expected %0h (t=%0t)", nm, bad_k,
                     ifc.mem_data[bad_k*WB +: WB], exp[bad_k*WB +: WB], $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got no handshake, expected one within 200 cycles", nm);
    endtask

    // Model update on each rising edge from the inputs and its own ready flags.
    initial begin
        forever begin
            @(posedge clk);
            started = 1'b1;
            if (rst) begin
                m_active = 1'b0;
                m_commit = 1'b0;
                m_rdy    = 1'b0;
                m_addr   = '0;
                m_left   = '0;
                m_k      = 0;
                for (int k = 0; k < NW; k++) m_slot[k] = '0;
            end else begin
                if (m_commit) begin
                    m_commit = 1'b0;
                    if (m_left > 1) begin
                        m_left = m_left - 1'b1;
                        m_addr = m_addr + 1'b1;
                        m_k    = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else if (m_active) begin
                    if (ifc.in_valid === 1'b1) begin
                        m_slot[m_k] = ifc.in_word;
                        m_k++;
                        if (m_k == NW) m_commit = 1'b1;
                    end
                end else if (m_rdy && ifc.cmd_valid === 1'b1) begin
                    m_active = 1'b1;
                    m_addr   = ifc.cmd_addr;
                    m_k      = 0;
`ifdef CTRL_PACKER_MULTIBLOCK_EN
                    m_left   = (ifc.cmd_nblocks == '0) ? AB'(1) : ifc.cmd_nblocks;
`else
                    m_left   = AB'(1);
`endif
                end
                m_rdy = 1'b1;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("cmd_ready", 64'(ifc.cmd_ready), 64'(m_rdy && !m_active));
                chk("in_ready",  64'(ifc.in_ready),  64'(m_active && !m_commit));
                chk("busy",      64'(ifc.busy),      64'(m_active));
                chk("mem_write", 64'(ifc.mem_write), 64'(m_commit));
                chk("done",      64'(ifc.done),      64'(m_commit && m_left == AB'(1)));
                chk("mem_addr",  64'(ifc.mem_addr),  64'(m_addr));
                chk_data("mem_data", m_line());
                if (ifc.mem_write === 1'b1) wr_log.push_back(ifc.mem_addr);
                if (ifc.done === 1'b1) done_cnt++;
            end
        end
    end

    task automatic send_cmd(input logic [AB-1:0] a);
        int n;
        n = 0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_addr  = a;
        while (ifc.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail("cmd handshake");
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic send_words(input logic [WB-1:0] base, input int count, input bit gap);
        int n;
        for (int i = 0; i < count; i++) begin
            n = 0;
            ifc.in_valid = 1'b1;
            ifc.in_word  = base + WB'(i);
            while (ifc.in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                timeout_fail("word handshake");
                break;
            end
            @(negedge clk);
            if (gap && i != count - 1) begin
                ifc.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        ifc.in_valid = 1'b0;
    endtask

    // Called on the falling edge right after the last word was accepted.
    task automatic expect_write(input string nm, input logic [AB-1:0] a);
        int n;
        chk({nm, " write latency"}, 64'(ifc.mem_write), 64'(1));
        n = 0;
        while (ifc.mem_write !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail({nm, " write"});
        chk({nm, " addr"}, 64'(ifc.mem_addr), 64'(a));
        chk({nm, " done"}, 64'(ifc.done), 64'(1));
        chk({nm, " cmd_ready in commit"}, 64'(ifc.cmd_ready), 64'(0));
        chk({nm, " in_ready in commit"}, 64'(ifc.in_ready), 64'(0));
    endtask

    task automatic chk_reset_values(input string nm);
        chk({nm, " cmd_ready"}, 64'(ifc.cmd_ready), 64'(0));
        chk({nm, " in_ready"},  64'(ifc.in_ready),  64'(0));
        chk({nm, " mem_write"}, 64'(ifc.mem_write), 64'(0));
        chk({nm, " mem_addr"},  64'(ifc.mem_addr),  64'(0));
        chk({nm, " busy"},      64'(ifc.busy),      64'(0));
        chk({nm, " done"},      64'(ifc.done),      64'(0));
        chk_data({nm, " mem_data"}, '0);
    endtask

    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_addr  = '0;
        ifc.in_valid  = 1'b0;
        ifc.in_word   = '0;
`ifdef CTRL_PACKER_MULTIBLOCK_EN
        ifc.cmd_nblocks = AB'(1);
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready after reset", 64'(ifc.cmd_ready), 64'(1));

        // Block at address 5, words 0..63 back-to-back.
        send_cmd(6'd5);
        send_words(16'h0000, NW, 1'b0);
        expect_write("blk5", 6'd5);
        for (int k = 0; k < NW; k++) chk("blk5 slot", 64'(slot(k)), 64'(k));
        @(negedge clk);
        chk("blk5 cmd_ready back", 64'(ifc.cmd_ready), 64'(1));
        chk("blk5 single strobe", 64'(ifc.mem_write), 64'(0));

        // Block at address 12 with in_valid only every other cycle.
        send_cmd(6'd12);
        send_words(16'hA000, NW, 1'b1);
        expect_write("blk12", 6'd12);
        chk("blk12 slot63", 64'(slot(63)), 64'h A03F);
        chk("blk12 slot0",  64'(slot(0)),  64'h A000);

        // Command raised during the commit cycle is taken only afterwards.
        ifc.cmd_valid = 1'b1;
        ifc.cmd_addr  = 6'd33;
        @(negedge clk);
        chk("cmd in commit not taken busy", 64'(ifc.busy), 64'(0));
        chk("cmd in commit cmd_ready", 64'(ifc.cmd_ready), 64'(1));
        @(negedge clk);
        chk("cmd after commit taken", 64'(ifc.busy), 64'(1));
        chk("cmd after commit addr", 64'(ifc.mem_addr), 64'(33));
        ifc.cmd_valid = 1'b0;
        send_words(16'h5000, NW, 1'b0);
        expect_write("blk33", 6'd33);
        chk("blk33 slot0", 64'(slot(0)), 64'h5000);
        @(negedge clk);

        // Stream words offered in IDLE are ignored, including at the command cycle.
        for (int i = 0; i < 10; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_word  = 16'hFFFF;
            @(negedge clk);
            chk("idle in_ready", 64'(ifc.in_ready), 64'(0));
            chk("idle mem_write", 64'(ifc.mem_write), 64'(0));
        end
        send_cmd(6'd20);
        send_words(16'h1230, NW, 1'b0);
        expect_write("blk20", 6'd20);
        chk("blk20 slot0", 64'(slot(0)), 64'h1230);
        chk("blk20 slot1", 64'(slot(1)), 64'h1231);
        @(negedge clk);

        // Reset after 30 words of a block: partial block dropped, fresh block written.
        send_cmd(6'd7);
        send_words(16'h5500, 30, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values("mid-fill reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post-reset no write", 64'(ifc.mem_write), 64'(0));
        end
        send_cmd(6'd7);
        send_words(16'h7000, NW, 1'b0);
        expect_write("blk7", 6'd7);
        chk("blk7 slot0",  64'(slot(0)),  64'h7000);
        chk("blk7 slot29", 64'(slot(29)), 64'h701D);
        chk("blk7 slot63", 64'(slot(63)), 64'h703F);
        @(negedge clk);

`ifdef CTRL_PACKER_MULTIBLOCK_EN
        // Three blocks starting at 62: addresses wrap 62, 63, 0; one done pulse.
        wr_log.delete();
        done_cnt = 0;
        ifc.cmd_nblocks = 6'd3;
        send_cmd(6'd62);
        send_words(16'h3000, 3 * NW, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("multi write count", 64'(wr_log.size()), 64'(3));
        if (wr_log.size() >= 3) begin
            chk("multi addr 0", 64'(wr_log[0]), 64'(62));
            chk("multi addr 1", 64'(wr_log[1]), 64'(63));
            chk("multi addr 2", 64'(wr_log[2]), 64'(0));
        end
        chk("multi done count", 64'(done_cnt), 64'(1));
        chk("multi last slot0", 64'(slot(0)), 64'h3080);
        chk("multi last slot63", 64'(slot(63)), 64'h30BF);
        ifc.cmd_nblocks = AB'(1);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
